// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : btn_pkg
// Description : Shared types and helpers for the push-button conditioner:
//               debounce FSM state encoding and the ms-to-cycles conversion
//               used to size the debounce and long-press counters.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Milliseconds to clock cycles. The divide is done first so that large
    // clock rates multiplied by long intervals stay inside 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One push-button channel: 2-FF synchroniser, debounce FSM with
//               stability counter, registered level and press/release strobes,
//               and an optional hold counter for a one-shot long-press strobe.
// Config      : LONG_PRESS_EN - build the hold counter and drive o_long_pulse;
//               when undefined o_long_pulse is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam int unsigned c_DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned c_LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int          c_DB_W     = $clog2(c_DB_CYC + 1);

    // Final debounce count: the state is accepted on the cycle the counter
    // would step onto this value, so DB_CYC consecutive samples are needed.
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(c_DB_CYC - 1);

    // A debounce window under two cycles cannot separate entry from acceptance
    if (c_DB_CYC < 2) begin : g_db_cyc_check
        $error("btn_debounce_ch: DB_CYC=%0d must be >= 2 (LONG_CYC=%0d)",
               c_DB_CYC, c_LONG_CYC);
    end

    logic              r_sync_0;
    logic              r_sync_1;
    logic              w_s;
    btn_state_t        r_state;
    btn_state_t        w_state_next;
    logic [c_DB_W-1:0] r_cnt;
    logic [c_DB_W-1:0] w_cnt_next;
    logic [c_DB_W-1:0] w_cnt_inc;
    logic              r_level;
    logic              w_level_next;
    logic              r_press;
    logic              w_press_next;
    logic              r_release;
    logic              w_release_next;

    // Two-flop synchroniser; resets to the released (high) pin value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_0 <= 1'b1;
            r_sync_1 <= 1'b1;
        end else begin
            r_sync_0 <= i_btn_n;
            r_sync_1 <= r_sync_0;
        end
    end

    // Synchronised pin, still active-low (0 = pressed)
    assign w_s       = r_sync_1;
    assign w_cnt_inc = r_cnt + c_DB_W'(1);

    // FSM state, stability counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    // Next-state and output decode: a pin change must persist through the
    // whole wait state, any disagreeing sample aborts back to the stable state
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_level_next   = r_level;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        case (r_state)
            RELEASED: begin
                if (!w_s) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (w_s) begin
                    w_state_next = RELEASED;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc == c_DB_LAST) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_level_next = 1'b1;
                    w_press_next = 1'b1;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            PRESSED: begin
                if (w_s) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!w_s) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc == c_DB_LAST) begin
                    w_state_next   = RELEASED;
                    w_cnt_next     = '0;
                    w_level_next   = 1'b0;
                    w_release_next = 1'b1;
                end else begin
                    w_cnt_next     = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = RELEASED;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_btn_level     = r_level;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;

`ifdef LONG_PRESS_EN
    localparam int                  c_LONG_W    = $clog2(c_LONG_CYC + 1);
    localparam logic [c_LONG_W-1:0] c_LONG_LAST = c_LONG_W'(c_LONG_CYC - 1);
    localparam logic [c_LONG_W-1:0] c_LONG_SAT  = c_LONG_W'(c_LONG_CYC);

    logic [c_LONG_W-1:0] r_hold;
    logic                r_long;

    // Hold counter: counts stable pressed cycles, pauses during release
    // bounces, saturates after firing so each press gives one strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (r_state == RELEASED || r_state == PRESS_WAIT) begin
                r_hold <= '0;
            end else if (r_state == PRESSED && !w_s && r_hold != c_LONG_SAT) begin
                r_hold <= r_hold + c_LONG_W'(1);
                r_long <= (r_hold == c_LONG_LAST);
            end
        end
    end

    assign o_long_pulse = r_long;
`else
    assign o_long_pulse = 1'b0;
`endif

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Front end for the active-low board push-buttons. Each pin is
//               synchronised and debounced independently into a clean level
//               plus one-cycle press / release (and optional long-press)
//               strobes for downstream LED and counter control.
// Config      : LONG_PRESS_EN - enable the long-press strobe on long_pulse;
//               when undefined long_pulse is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN       = 3,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    // One fully independent conditioner per button pin
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .CLK_HZ      (CLK_HZ),
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_btn_n         (btn_n[i]),
            .o_btn_level     (btn_level[i]),
            .o_press_pulse   (press_pulse[i]),
            .o_release_pulse (release_pulse[i]),
            .o_long_pulse    (long_pulse[i])
        );
    end

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. A behavioural
//               model (run-length of disagreeing samples, press-hold sample
//               count) is compared every cycle; directed scenarios pin
//               latencies and boundaries with literal values; a randomised
//               phase mixes bounces, long holds and asynchronous resets.
// Config      : LONG_PRESS_EN - expect long-press strobes when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int N        = 3;
    localparam int DB_CYC   = 4;    // 1000 Hz, 4 ms
    localparam int LONG_CYC = 20;   // 1000 Hz, 20 ms

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_n;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .N_BTN       (N),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. The pin reaches the decision logic two samples
    // late. A level change is accepted once DB_CYC consecutive samples
    // disagree with the current level. The long strobe fires on the
    // LONG_CYC-th sample after acceptance in which the button is pressed,
    // settled and agreeing (samples during a release bounce do not count).
    // ------------------------------------------------------------------
    logic [N-1:0] m_h0, m_h1, m_level, m_press, m_release, m_long;
    int           m_run  [N];
    int           m_hold [N];

    initial begin
        m_h0 = '1; m_h1 = '1; m_level = '0;
        m_press = '0; m_release = '0; m_long = '0;
        for (int c = 0; c < N; c++) begin m_run[c] = 0; m_hold[c] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_h0 = '1; m_h1 = '1; m_level = '0;
                m_press = '0; m_release = '0; m_long = '0;
                for (int c = 0; c < N; c++) begin m_run[c] = 0; m_hold[c] = 0; end
            end else begin
                for (int c = 0; c < N; c++) begin
                    logic pressed_now;
                    pressed_now  = ~m_h1[c];
                    m_press[c]   = 1'b0;
                    m_release[c] = 1'b0;
                    m_long[c]    = 1'b0;
                    if (m_level[c] && m_run[c] == 0 && pressed_now) begin
                        m_hold[c]++;
`ifdef LONG_PRESS_EN
                        if (m_hold[c] == LONG_CYC) m_long[c] = 1'b1;
`endif
                    end
                    if (pressed_now != m_level[c]) m_run[c]++;
                    else                           m_run[c] = 0;
                    if (m_run[c] == DB_CYC) begin
                        m_level[c] = pressed_now;
                        if (pressed_now) m_press[c]   = 1'b1;
                        else             m_release[c] = 1'b1;
                        m_run[c]  = 0;
                        m_hold[c] = 0;
                    end
                end
                m_h1 = m_h0;
                m_h0 = btn_n;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check_vec("model_level",   btn_level,     m_level);
        check_vec("model_press",   press_pulse,   m_press);
        check_vec("model_release", release_pulse, m_release);
        check_vec("model_long",    long_pulse,    m_long);
    end

    // Scan a window of cycles on one channel: first cycle (1-based, counted
    // from the last drive) and number of each strobe type.
    task automatic scan(input int ch, input int ncyc,
                        output int pf, output int pc,
                        output int rf, output int rc,
                        output int lf, output int lc);
        pf = -1; pc = 0; rf = -1; rc = 0; lf = -1; lc = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (press_pulse[ch])   begin pc++; if (pf < 0) pf = k; end
            if (release_pulse[ch]) begin rc++; if (rf < 0) rf = k; end
            if (long_pulse[ch])    begin lc++; if (lf < 0) lf = k; end
        end
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic bounce_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int pf, pc, rf, rc, lf, lc;
        int hits, k_hit;
        logic [N-1:0] vec_hit;
        int dur [N];
        int rst_cnt;

        // 1. Reset
        rst_n = 1'b0;
        btn_n = '1;
        step(3);
        check_vec("rst_level", btn_level, 3'b000);
        check_vec("rst_press", press_pulse, 3'b000);
        check_int("rst_state0", int'(dut.g_ch[0].u_ch.r_state), int'(RELEASED));
        check_int("rst_state1", int'(dut.g_ch[1].u_ch.r_state), int'(RELEASED));
        check_int("rst_state2", int'(dut.g_ch[2].u_ch.r_state), int'(RELEASED));
        rst_n = 1'b1;
        step(3);
        check_vec("post_rst_level", btn_level, 3'b000);

        // 2. Clean press on channel 0: strobe six clocks after the pin change
        btn_n[0] = 1'b0;
        scan(0, 12, pf, pc, rf, rc, lf, lc);
        check_int("press0_latency", pf, DB_CYC + 2);
        check_int("press0_count", pc, 1);
        check_vec("press0_level", btn_level, 3'b001);

        // 4. Release of channel 0, symmetric latency
        btn_n[0] = 1'b1;
        scan(0, 12, pf, pc, rf, rc, lf, lc);
        check_int("release0_latency", rf, DB_CYC + 2);
        check_int("release0_count", rc, 1);
        check_int("release0_nopress", pc, 0);
        check_vec("release0_level", btn_level, 3'b000);

        // 3. Bounce shorter than the debounce window
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            btn_n[0] = bounce_pat[i];
            @(negedge clk);
            if (press_pulse[0] || btn_level[0]) hits++;
            #1;
        end
        btn_n[0] = 1'b1;
        scan(0, 15, pf, pc, rf, rc, lf, lc);
        check_int("bounce_no_event", hits + pc + rc, 0);
        check_vec("bounce_level", btn_level, 3'b000);

        // 5. Long hold on channel 1
        btn_n[1] = 1'b0;
        scan(1, 40, pf, pc, rf, rc, lf, lc);
        check_int("hold1_press_latency", pf, DB_CYC + 2);
        check_int("hold1_press_count", pc, 1);
`ifdef LONG_PRESS_EN
        check_int("long1_count", lc, 1);
        check_int("long1_delay", lf - pf, LONG_CYC);
`else
        check_int("long1_absent", lc, 0);
`endif
        btn_n[1] = 1'b1;
        scan(1, 12, pf, pc, rf, rc, lf, lc);
        check_int("hold1_release_count", rc, 1);

        // 6a. Simultaneous presses on channels 0 and 2
        btn_n = 3'b010;
        k_hit = -1; vec_hit = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (press_pulse != '0 && k_hit < 0) begin k_hit = k; vec_hit = press_pulse; end
        end
        #1;
        check_vec("simul_press_vec", vec_hit, 3'b101);
        check_int("simul_press_latency", k_hit, DB_CYC + 2);
        btn_n = 3'b111;
        step(12);

        // 6b. Reset during PRESS_WAIT with another channel already pressed
        btn_n = 3'b101;
        scan(1, 12, pf, pc, rf, rc, lf, lc);
        check_vec("pre_rst_level", btn_level, 3'b010);
        btn_n = 3'b100;
        step(3);
        rst_n = 1'b0;
        #1;
        check_vec("rst_immediate_level", btn_level, 3'b000);
        btn_n = 3'b111;
        step(2);
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (press_pulse != '0) hits++;
        end
        #1;
        check_int("rst_pending_dropped", hits, 0);

        // Button held through reset deassertion is a fresh press
        btn_n = 3'b011;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        scan(2, 12, pf, pc, rf, rc, lf, lc);
        check_int("held_rst_press_latency", pf, DB_CYC + 2);
        check_int("held_rst_press_count", pc, 1);
        btn_n = 3'b111;
        step(12);

        // Randomised phase: bounces, clean presses, long holds, async resets
        for (int c = 0; c < N; c++) dur[c] = int'($urandom_range(1, 10));
        rst_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            #1;
            for (int c = 0; c < N; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    btn_n[c] = ~btn_n[c];
                    if ($urandom_range(0, 5) == 0) dur[c] = int'($urandom_range(22, 45));
                    else                           dur[c] = int'($urandom_range(1, 2 * DB_CYC + 2));
                end
            end
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                #2;
                rst_n   = 1'b0;
                rst_cnt = int'($urandom_range(1, 3));
            end
        end
        rst_n = 1'b1;
        step(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
